// File: rtl/wb_spi_initiator_if.sv
// rtl/wb_spi_initiator_if.sv - SPI pin and Wishbone initiator bundle for wb_spi_initiator
`timescale 1ns/1ps
interface wb_spi_initiator_if;
    logic        i_spi_csb;
    logic        i_spi_sclk;
    logic        i_spi_mosi;
    logic        o_spi_miso;
    logic        o_spi_miso_oeb;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        o_busy;
    logic        o_err;

    modport master (
        input  i_spi_csb, i_spi_sclk, i_spi_mosi, wbm_dat_i, wbm_ack_i,
        output o_spi_miso, o_spi_miso_oeb, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_sel_o, wbm_adr_o, wbm_dat_o, o_busy, o_err
    );

    modport slave (
        output i_spi_csb, i_spi_sclk, i_spi_mosi, wbm_dat_i, wbm_ack_i,
        input  o_spi_miso, o_spi_miso_oeb, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_sel_o, wbm_adr_o, wbm_dat_o, o_busy, o_err
    );
endinterface

// File: rtl/wb_spi_initiator.sv
// rtl/wb_spi_initiator.sv - SPI target frames to Wishbone classic cycles; ack timeout under WB_SPI_INITIATOR_TIMEOUT_EN
`timescale 1ns/1ps
module wb_spi_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    wb_spi_initiator_if.master    bus
);
    typedef enum logic [1:0] {IDLE, RX, BUS, TX} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  csb_sync, sclk_sync, mosi_sync;
    logic        csb_prev, sclk_prev;
    logic        settled, armed;
    logic [6:0]  bit_cnt;
    logic [62:0] frame;
    logic [31:0] tx_shift;
    logic        late;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        timeout_hit;

    wire csb_s      = csb_sync[1];
    wire mosi_s     = mosi_sync[1];
    wire sclk_rise  = sclk_sync[1] & ~sclk_prev;
    wire sclk_fall  = ~sclk_sync[1] & sclk_prev;
    wire start_read  = (bit_cnt == 7'd39) && !frame[38];
    wire start_write = (bit_cnt == 7'd71);
    wire bus_enter  = (state == RX) && !csb_s && sclk_rise && (start_read || start_write);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            csb_sync  <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            csb_prev  <= 1'b1;
            sclk_prev <= 1'b0;
            settled   <= 1'b0;
            armed     <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= '0;
            frame     <= '0;
            tx_shift  <= '0;
            late      <= 1'b0;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            we        <= 1'b0;
            sel       <= '0;
            adr       <= '0;
            dat       <= '0;
        end else begin
            csb_sync  <= {csb_sync[0], bus.i_spi_csb};
            sclk_sync <= {sclk_sync[0], bus.i_spi_sclk};
            mosi_sync <= {mosi_sync[0], bus.i_spi_mosi};
            csb_prev  <= csb_s;
            sclk_prev <= sclk_sync[1];
            // A CSB held low across reset must be seen high before a frame can start
            settled   <= 1'b1;
            if (settled && csb_sync[0])
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    late <= 1'b0;
                    if (armed && csb_prev && !csb_s) begin
                        state   <= RX;
                        bit_cnt <= '0;
                    end
                end
                RX: begin
                    if (csb_s) begin
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        frame   <= {frame[61:0], mosi_s};
                        bit_cnt <= bit_cnt + 7'd1;
                        if (bus_enter) begin
                            state <= BUS;
                            cyc   <= 1'b1;
                            stb   <= 1'b1;
                            sel   <= 4'hF;
                            we    <= start_write;
                            adr   <= start_write ? frame[62:31] : {frame[30:0], mosi_s};
                            if (start_write)
                                dat <= {frame[30:0], mosi_s};
                        end
                    end
                end
                BUS: begin
                    if (sclk_rise && bit_cnt < 7'd80)
                        bit_cnt <= bit_cnt + 7'd1;
                    // Responder too slow: data phase already running, return all ones
                    if (!we && bit_cnt >= 7'd48)
                        late <= 1'b1;
                    if (bus.wbm_ack_i) begin
                        cyc      <= 1'b0;
                        stb      <= 1'b0;
                        state    <= TX;
                        tx_shift <= we ? 32'h0 : bus.wbm_dat_i;
                    end else if (timeout_hit) begin
                        cyc      <= 1'b0;
                        stb      <= 1'b0;
                        state    <= TX;
                        tx_shift <= 32'hFFFF_FFFF;
                    end
                end
                TX: begin
                    if (csb_s) begin
                        state <= IDLE;
                    end else begin
                        if (sclk_rise && bit_cnt < 7'd80)
                            bit_cnt <= bit_cnt + 7'd1;
                        // MSB is presented at TX entry; shift only after each data bit is sampled
                        if (sclk_fall && bit_cnt >= 7'd49 && bit_cnt <= 7'd79)
                            tx_shift <= {tx_shift[30:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_SPI_INITIATOR_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       err_q;

    assign timeout_hit = (state == BUS) && !bus.wbm_ack_i && (to_cnt == TO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (bus_enter) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (state == BUS && !bus.wbm_ack_i) begin
            to_cnt <= to_cnt + 8'd1;
            if (to_cnt == TO_LAST)
                err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^{TO_LAST, bus_enter};
    assign timeout_hit    = 1'b0;
    assign bus.o_err      = 1'b0;
`endif

    assign bus.wbm_cyc_o      = cyc;
    assign bus.wbm_stb_o      = stb;
    assign bus.wbm_we_o       = we;
    assign bus.wbm_sel_o      = sel;
    assign bus.wbm_adr_o      = adr;
    assign bus.wbm_dat_o      = dat;
    assign bus.o_busy         = (state != IDLE);
    assign bus.o_spi_miso_oeb = csb_s;
    assign bus.o_spi_miso     = late | ((state == TX) & tx_shift[31]);
endmodule

// File: tb/tb_wb_spi_initiator.sv
// tb/tb_wb_spi_initiator.sv - scoreboard bench for wb_spi_initiator with random frames and a frame-level model
`timescale 1ns/1ps
module tb_wb_spi_initiator;
    localparam int HALF = 8;
    localparam int TO   = 16;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          len;
    } bus_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ack_delay = 0;
    logic [31:0] resp_data = '0;
    bus_exp_t    exp_bus[$];
    logic [31:0] exp_miso[$];

    wb_spi_initiator_if bus();

    wb_spi_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_start();
        bus.i_spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_shift(input logic [79:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_spi_mosi = bits[79-i];
            repeat (HALF) @(negedge clk);
            bus.i_spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.i_spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_stop();
        repeat (HALF) @(negedge clk);
        bus.i_spi_csb = 1'b1;
        repeat (3*HALF) @(negedge clk);
    endtask

    // Model: one transaction is fully described by command, address, data and the ack latency
    task automatic do_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [31:0] resp, input int delay);
        logic [79:0] bits;
        ack_delay = delay;
        resp_data = resp;
        if (cmd[7]) begin
            bits = {cmd, adr, dat, 8'h00};
            exp_bus.push_back('{1'b1, adr, dat, delay + 1});
            spi_start();
            spi_shift(bits, 72);
        end else begin
            bits = {cmd, adr, 8'h00, $urandom()};
            exp_bus.push_back('{1'b0, adr, 32'h0, (delay < 0) ? TO : delay + 1});
            exp_miso.push_back((delay < 0) ? 32'hFFFF_FFFF : resp);
            spi_start();
            spi_shift(bits, 80);
        end
        spi_stop();
    endtask

    // Responder: drives ack `ack_delay` clocks after it first sees the request
    initial begin
        int cnt;
        cnt = 0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                bus.wbm_ack_i = 1'b0;
                cnt = 0;
            end else if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                if (bus.wbm_ack_i) begin
                    bus.wbm_ack_i = 1'b0;
                end else if (ack_delay >= 0 && cnt >= ack_delay) begin
                    bus.wbm_ack_i = 1'b1;
                    bus.wbm_dat_i = resp_data;
                end else begin
                    cnt++;
                    bus.wbm_dat_i = $urandom();
                end
            end else begin
                bus.wbm_ack_i = 1'b0;
                cnt = 0;
            end
        end
    end

    // Bus monitor
    initial begin
        logic prev_cyc, ack_prev, stable;
        int len;
        bus_exp_t cur;
        prev_cyc = 1'b0;
        ack_prev = 1'b0;
        stable   = 1'b1;
        len      = 0;
        cur      = '{1'b0, 32'h0, 32'h0, -1};
        forever begin
            @(negedge clk);
            if (ack_prev)
                chk("cyc_drop_after_ack", bus.wbm_cyc_o, 1'b0);
            if (bus.wbm_cyc_o && !prev_cyc) begin
                len = 1;
                stable = 1'b1;
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cycle: got cyc at adr %0h expected none", bus.wbm_adr_o);
                    cur = '{bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, -1};
                end else begin
                    cur = exp_bus.pop_front();
                    chk("bus_we", bus.wbm_we_o, cur.we);
                    chk("bus_sel", bus.wbm_sel_o, 4'hF);
                    chk("bus_stb", bus.wbm_stb_o, 1'b1);
                    chk("bus_adr", bus.wbm_adr_o, cur.adr);
                    if (cur.we)
                        chk("bus_dat", bus.wbm_dat_o, cur.dat);
                    else
                        cur.dat = bus.wbm_dat_o;
                end
            end else if (bus.wbm_cyc_o) begin
                len++;
                if (bus.wbm_adr_o !== cur.adr || bus.wbm_we_o !== cur.we || bus.wbm_sel_o !== 4'hF ||
                    bus.wbm_stb_o !== 1'b1 || bus.wbm_dat_o !== cur.dat)
                    stable = 1'b0;
            end else if (prev_cyc) begin
                chk("bus_stable", stable, 1'b1);
                if (cur.len >= 0)
                    chk("cyc_length", len, cur.len);
            end
            prev_cyc = bus.wbm_cyc_o;
            ack_prev = bus.wbm_ack_i && bus.wbm_cyc_o;
        end
    end

    // MISO monitor: captures bits 48..79 of every complete 80-bit frame
    initial begin
        int nb;
        logic [31:0] word;
        logic [31:0] exp;
        forever begin
            @(negedge bus.i_spi_csb);
            nb = 0;
            word = '0;
            while (bus.i_spi_csb == 1'b0) begin
                @(posedge bus.i_spi_sclk or posedge bus.i_spi_csb);
                if (!bus.i_spi_csb) begin
                    if (nb >= 48 && nb < 80)
                        word = {word[30:0], bus.o_spi_miso};
                    nb++;
                end
            end
            if (nb == 80) begin
                if (exp_miso.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read_word: got %0h expected none", word);
                end else begin
                    exp = exp_miso.pop_front();
                    chk("miso_word", word, exp);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, r;
        logic [7:0]  c;
        bus.i_spi_csb  = 1'b1;
        bus.i_spi_sclk = 1'b0;
        bus.i_spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", bus.wbm_cyc_o, 1'b0);
        chk("rst_stb", bus.wbm_stb_o, 1'b0);
        chk("rst_sel_adr_dat", {bus.wbm_sel_o, bus.wbm_adr_o[27:0]} | bus.wbm_dat_o, 32'h0);
        chk("rst_miso_oeb", {bus.o_spi_miso, bus.o_spi_miso_oeb}, 2'b01);
        chk("rst_busy_err", {bus.o_busy, bus.o_err}, 2'b00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed write, then check the pad enable follows CSB
        do_frame(8'h80, 32'h3000_0010, 32'hCAFE_F00D, 32'h0, 3);
        bus.i_spi_csb = 1'b0;
        repeat (4) @(negedge clk);
        chk("oeb_low_in_frame", bus.o_spi_miso_oeb, 1'b0);
        bus.i_spi_csb = 1'b1;
        repeat (3*HALF) @(negedge clk);

        do_frame(8'h00, 32'h3000_0004, 32'h0, 32'h1234_5678, 2);

        // Aborted write after 20 bits
        spi_start();
        spi_shift({8'h80, 32'h3000_0010, 40'h0}, 20);
        bus.i_spi_csb = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_busy", bus.o_busy, 1'b0);
        repeat (3*HALF) @(negedge clk);

`ifdef WB_SPI_INITIATOR_TIMEOUT_EN
        do_frame(8'h00, 32'h0000_0100, 32'h0, 32'h0, -1);
        chk("timeout_err", bus.o_err, 1'b1);
`endif

        for (int k = 0; k < 10; k++) begin
            c = 8'($urandom());
            a = $urandom();
            d = $urandom();
            r = $urandom();
            do_frame(c, a, d, r, int'($urandom_range(0, 6)));
        end
        chk("err_clear", bus.o_err, 1'b0);

        // Reset pulse during the BUS phase of a read with no responder
        ack_delay = -1;
        exp_bus.push_back('{1'b0, 32'h5A5A_0F0F, 32'h0, -1});
        spi_start();
        spi_shift({8'h00, 32'h5A5A_0F0F, 40'h0}, 40);
        for (int i = 0; i < 100 && !bus.wbm_cyc_o; i++)
            @(negedge clk);
        chk("hang_cyc_seen", bus.wbm_cyc_o, 1'b1);
`ifndef WB_SPI_INITIATOR_TIMEOUT_EN
        repeat (300) @(negedge clk);
        chk("hold_cyc", bus.wbm_cyc_o, 1'b1);
        chk("hold_err", bus.o_err, 1'b0);
`endif
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 3'b000);
        chk("async_sel_adr_dat", {bus.wbm_sel_o, bus.wbm_adr_o[27:0]} | bus.wbm_dat_o, 32'h0);
        chk("async_pins", {bus.o_spi_miso, bus.o_spi_miso_oeb, bus.o_busy, bus.o_err}, 4'b0100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_start_without_edge", bus.o_busy, 1'b0);
        bus.i_spi_csb = 1'b1;
        repeat (3*HALF) @(negedge clk);

        do_frame(8'h80, 32'h1111_2222, 32'h3333_4444, 32'h0, 1);
        do_frame(8'h7F, 32'hDEAD_BEEF, 32'h0, 32'h8000_0001, 0);

        repeat (50) @(negedge clk);
        chk("exp_bus_drained", exp_bus.size(), 0);
        chk("exp_miso_drained", exp_miso.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_spi_initiator.md
WB_SPI_INITIATOR -- requirements
Module: wb_spi_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max wb_clk_i cycles to wait for wbm_ack_i (1..255).
REQ-002 SHALL have port wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_spi_csb  input  1  host chip-select, active-low, asynchronous to wb_clk_i.
REQ-005 SHALL have port i_spi_sclk  input  1  host SPI clock, mode 0, asynchronous, at most wb_clk_i/8.
REQ-006 SHALL have port i_spi_mosi  input  1  host data in, MSB first.
REQ-007 SHALL have port o_spi_miso  output  1  read data out, MSB first.
REQ-008 SHALL have port o_spi_miso_oeb  output  1  pad output-enable-bar; 0 only while synchronised CSB low.
REQ-009 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic initiator controls.
REQ-010 SHALL have ports wbm_sel_o  output  4, wbm_adr_o  output  32, wbm_dat_o  output  32.
REQ-011 SHALL have ports wbm_dat_i  input  32, wbm_ack_i  input  1  responder data and acknowledge.
REQ-012 SHALL have ports o_busy  output  1 (state not IDLE), o_err  output  1 (sticky last-transaction timeout).

Function
REQ-013 CSB, SCLK, MOSI SHALL pass through 2-flop synchronisers; SCLK rise/fall detected from synchronised samples.
REQ-014 States SHALL be IDLE, RX, BUS, TX; synchronised CSB falling edge moves IDLE->RX, clears 7-bit bit counter.
REQ-015 In RX each SCLK rise SHALL shift MOSI into the frame register and increment the counter.
REQ-016 Frame: bits 0-7 command (bit7=1 write, 0 read, bits 6:0 ignored), bits 8-39 address, bits 40-71 write data.
REQ-017 Write: after bit 71 SHALL enter BUS with cyc=stb=we=1, sel=4'hF, adr/dat from frame, on the next clock.
REQ-018 Read: after bit 39 SHALL enter BUS with cyc=stb=1, we=0, sel=4'hF; host then clocks 8 dummy bits, then 32 data bits.
REQ-019 In BUS, cyc/stb SHALL stay high until the clock where wbm_ack_i=1 is sampled, then drop on the next clock; adr/dat/we/sel held stable throughout.
REQ-020 Read ack SHALL capture wbm_dat_i into the TX shift register and enter TX; write ack SHALL enter TX with shift register loaded with 32'h0.
REQ-021 In TX, o_spi_miso SHALL equal shift-register MSB; shift on each SCLK fall after the 8th dummy bit; data bits valid before the following rise.
REQ-022 Ack not yet received at start of read data phase: MISO SHALL output 1 for all remaining bits.
REQ-023 CSB rising in RX SHALL discard the frame, start no bus cycle, return IDLE.
REQ-024 CSB rising in BUS SHALL NOT abort the cycle; cycle completes, then IDLE.
REQ-025 CSB rising in TX SHALL return IDLE; extra SCLK after 72 bits (write) or 80 bits (read) SHALL be ignored.
REQ-026 o_err SHALL clear at each new BUS entry and set only per REQ-033.

Reset
REQ-027 wb_rst_ni low SHALL immediately force state IDLE, cyc/stb/we=0, sel=0, adr=0, dat_o=0, o_spi_miso=0, o_spi_miso_oeb=1, o_busy=0, o_err=0, synchronisers to CSB=1/SCLK=0/MOSI=0.
REQ-028 Reset mid-BUS SHALL drop cyc/stb asynchronously; no retry after release.
REQ-029 After release, a new transaction SHALL require a fresh CSB falling edge.

Configuration
REQ-030 Macro WB_SPI_INITIATOR_TIMEOUT_EN SHALL control the ack timeout.
REQ-031 Defined: 8-bit counter, cleared on BUS entry, increments each BUS clock without ack.
REQ-032 Not defined: BUS waits indefinitely for ack; o_err constant 0; no counter logic.
REQ-033 Defined and counter reaches TIMEOUT_CYCLES: cyc/stb drop next clock, o_err=1, TX loaded with 32'hFFFF_FFFF.

Verification
REQ-034 Write frame cmd 8'h80, adr 32'h3000_0010, data 32'hCAFE_F00D, ack after 3 clocks -> one cyc/stb pulse, we=1, sel=F, exact adr/dat, cyc low 1 clock after ack.
REQ-035 Read frame cmd 8'h00, adr 32'h3000_0004, responder returns 32'h1234_5678 after 2 clocks -> MISO shifts 32'h1234_5678 MSB-first after 8 dummy bits.
REQ-036 CSB raised after 20 bits of write frame -> no cyc assertion, o_busy low within 4 clocks.
REQ-037 WB_SPI_INITIATOR_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ack never -> cyc drops after 16 BUS clocks, o_err=1, MISO reads 32'hFFFF_FFFF; macro undefined -> cyc held high indefinitely.
REQ-038 wb_rst_ni pulsed low during BUS of a read -> cyc/stb low without clock edge, all outputs at REQ-027 values, next full frame completes normally.
